cfg_word_deframer: RTL and testbench

//  Byte-stream to configuration-word deframer between a USB CDC channel and the eFPGA config port.

---
 rtl/cfg_word_deframer.sv | 210 +++++++++++++++++++++
 tb/tb_cfg_word_deframer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cfg_word_deframer.sv
// Byte-stream to config-word deframer: sync hunt, word count, MSB-first word assembly, status reply.
// Optional trailing checksum byte when CFG_DEFRAMER_CHECKSUM_EN is defined.
module cfg_word_deframer #(
  parameter int unsigned WORD_WIDTH     = 32,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter int unsigned LEN_BYTES      = 2,
  parameter int unsigned STROBE_GAP     = 0,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [7:0]            out_data_i,
  input  logic                  out_valid_i,
  output logic                  out_ready_o,
  output logic [7:0]            in_data_o,
  output logic                  in_valid_o,
  input  logic                  in_ready_i,
  output logic                  word_write_strobe_o,
  output logic [WORD_WIDTH-1:0] write_data_o,
  output logic                  busy_o
);
  localparam int unsigned BPW = WORD_WIDTH / 8;
  localparam int unsigned NW  = LEN_BYTES * 8;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned LW  = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;

  localparam logic [7:0] ST_ACK  = 8'h06;
  localparam logic [7:0] ST_CERR = 8'h15;
  localparam logic [7:0] ST_TMO  = 8'h18;

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_GAP, S_CSUM, S_RESP} state_t;

  state_t                state_q;
  logic [23:0]           hunt_q;
  logic [NW-1:0]         n_q;
  logic [LW-1:0]         lcnt_q;
  logic [BW-1:0]         bcnt_q;
  logic [TW-1:0]         tcnt_q;
  logic [7:0]            gcnt_q;
  logic                  done_q;
  logic                  acc;
  logic [31:0]           hunt_nxt;
  logic [NW-1:0]         n_nxt;
  logic [WORD_WIDTH-1:0] word_nxt;

  assign acc      = out_valid_i & out_ready_o;
  assign hunt_nxt = {hunt_q, out_data_i};
  assign busy_o   = (state_q != S_HUNT);

  if (LEN_BYTES > 1) begin : g_len
    assign n_nxt = {n_q[NW-9:0], out_data_i};
  end else begin : g_len1
    assign n_nxt = out_data_i;
  end

  // Only the leading WORD_WIDTH-8 bits need storage; the final byte goes straight to write_data_o.
  if (BPW > 1) begin : g_asm
    logic [WORD_WIDTH-9:0] asm_q;
    always_ff @(posedge clk_i) begin
      if (reset_i)                       asm_q <= '0;
      else if (acc && state_q == S_DATA) asm_q <= word_nxt[WORD_WIDTH-9:0];
    end
    assign word_nxt = {asm_q, out_data_i};
  end else begin : g_byte
    assign word_nxt = out_data_i;
  end

`ifdef CFG_DEFRAMER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sum_nxt;
  assign sum_nxt = sum_q + out_data_i;
`endif

  task automatic to_resp(input logic [7:0] code);
    state_q     <= S_RESP;
    out_ready_o <= 1'b0;
    in_valid_o  <= 1'b1;
    in_data_o   <= code;
  endtask

  task automatic end_payload();
`ifdef CFG_DEFRAMER_CHECKSUM_EN
    state_q     <= S_CSUM;
    out_ready_o <= 1'b1;
    tcnt_q      <= '0;
`else
    to_resp(ST_ACK);
`endif
  endtask

  // Idle cycle inside a frame: advance the inter-byte timer.
  task automatic tick();
    if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) to_resp(ST_TMO);
    else                                   tcnt_q <= tcnt_q + 1'b1;
  endtask

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q             <= S_HUNT;
      out_ready_o         <= 1'b0;
      in_valid_o          <= 1'b0;
      in_data_o           <= '0;
      word_write_strobe_o <= 1'b0;
      write_data_o        <= '0;
      hunt_q              <= '0;
      n_q                 <= '0;
      lcnt_q              <= '0;
      bcnt_q              <= '0;
      tcnt_q              <= '0;
      gcnt_q              <= '0;
      done_q              <= 1'b0;
`ifdef CFG_DEFRAMER_CHECKSUM_EN
      sum_q               <= '0;
`endif
    end else begin
      word_write_strobe_o <= 1'b0;
`ifdef CFG_DEFRAMER_CHECKSUM_EN
      if (acc && (state_q == S_LEN || state_q == S_DATA)) sum_q <= sum_nxt;
`endif
      unique case (state_q)
        S_HUNT: begin
          out_ready_o <= 1'b1;
          if (acc) begin
            hunt_q <= hunt_nxt[23:0];
            if (hunt_nxt == SYNC_WORD) begin
              state_q <= S_LEN;
              hunt_q  <= '0;
              n_q     <= '0;
              lcnt_q  <= '0;
              tcnt_q  <= '0;
`ifdef CFG_DEFRAMER_CHECKSUM_EN
              sum_q   <= '0;
`endif
            end
          end
        end
        S_LEN: begin
          if (acc) begin
            n_q    <= n_nxt;
            tcnt_q <= '0;
            if (lcnt_q == LW'(LEN_BYTES - 1)) begin
              lcnt_q <= '0;
              bcnt_q <= '0;
              if (n_nxt == '0) end_payload();
              else             state_q <= S_DATA;
            end else begin
              lcnt_q <= lcnt_q + 1'b1;
            end
          end else begin
            tick();
          end
        end
        S_DATA: begin
          if (acc) begin
            tcnt_q <= '0;
            if (bcnt_q == BW'(BPW - 1)) begin
              bcnt_q              <= '0;
              word_write_strobe_o <= 1'b1;
              write_data_o        <= word_nxt;
              if (n_q != '0) n_q <= n_q - 1'b1;
              if (STROBE_GAP > 0) begin
                state_q     <= S_GAP;
                out_ready_o <= 1'b0;
                gcnt_q      <= 8'(STROBE_GAP - 1);
                done_q      <= (n_q == NW'(1));
              end else if (n_q == NW'(1)) begin
                end_payload();
              end
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end else begin
            tick();
          end
        end
        S_GAP: begin
          if (gcnt_q == '0) begin
            if (done_q) end_payload();
            else begin
              state_q     <= S_DATA;
              out_ready_o <= 1'b1;
            end
          end else begin
            gcnt_q <= gcnt_q - 1'b1;
          end
        end
`ifdef CFG_DEFRAMER_CHECKSUM_EN
        S_CSUM: begin
          if (acc) to_resp((sum_nxt == 8'h00) ? ST_ACK : ST_CERR);
          else     tick();
        end
`endif
        S_RESP: begin
          if (in_ready_i) begin
            in_valid_o  <= 1'b0;
            state_q     <= S_HUNT;
            out_ready_o <= 1'b1;
            hunt_q      <= '0;
          end
        end
        default: begin
          state_q     <= S_HUNT;
          out_ready_o <= 1'b1;
          in_valid_o  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cfg_word_deframer.sv
// Scoreboard bench for cfg_word_deframer: random frames against a byte-list reference model.
module tb_cfg_word_deframer;
  localparam int WW = 32, BPW = WW / 8, LB = 2, GAP = 3, TMO = 300, BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    od = '0;
  logic          ov = 1'b0;
  logic          ordy;
  logic [7:0]    idata;
  logic          ivld;
  logic          irdy = 1'b0;
  logic          stb;
  logic [WW-1:0] wd;
  logic          busy;

  always #5 clk = ~clk;

  cfg_word_deframer #(
    .WORD_WIDTH(WW), .SYNC_WORD(32'hFAB0_FAB1), .LEN_BYTES(LB),
    .STROBE_GAP(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .reset_i(rst),
    .out_data_i(od), .out_valid_i(ov), .out_ready_o(ordy),
    .in_data_o(idata), .in_valid_o(ivld), .in_ready_i(irdy),
    .word_write_strobe_o(stb), .write_data_o(wd), .busy_o(busy)
  );

`ifdef CFG_DEFRAMER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  int checks = 0, passes = 0;
  logic [WW-1:0] exp_w[$];
  bit            exp_last[$];
  logic [7:0]    exp_st[$];
  logic [7:0]    pl[$];

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Word/gap monitor
  int gap_left = 0;
  bit chk_after = 0, exp_after = 0;
  always @(negedge clk) begin
    if (chk_after) begin
      chk("ready_after_gap", ordy, exp_after);
      chk_after = 0;
    end
    if (stb) begin
      if (exp_w.size() == 0) chk("strobe_unexpected", 1, 0);
      else begin
        logic [WW-1:0] w;
        bit l;
        w = exp_w.pop_front();
        l = exp_last.pop_front();
        chk("word", wd, w);
        gap_left  = GAP;
        exp_after = CS ? 1'b1 : !l;
      end
    end
    if (gap_left > 0) begin
      chk("ready_in_gap", ordy, 0);
      gap_left--;
      if (gap_left == 0) chk_after = 1;
    end
  end

  // Status monitor with random host back-pressure
  always @(negedge clk) begin
    irdy = 1'b0;
    if (ivld && !rst && $urandom_range(0, 2) != 0) begin
      irdy = 1'b1;
      if (exp_st.size() == 0) chk("status_unexpected", 1, 0);
      else chk("status", idata, exp_st.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin
      ov = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    od = b;
    ov = 1'b1;
    while (!ordy && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) chk("out_ready_stall", 1, 0);
    @(negedge clk);
  endtask

  // cut<0: complete frame; else only the first cut bytes after sync are sent.
  task automatic run_frame(input int nw, input int cut, input logic [7:0] cs_off);
    logic [7:0] fb[$];
    logic [7:0] sum;
    logic [7:0] sync_b[4];
    logic [7:0] noise_b[4];
    logic [WW-1:0] w;
    int np, nsent, t;
    sync_b  = '{8'hFA, 8'hB0, 8'hFA, 8'hB1};
    noise_b = '{8'h00, 8'hFA, 8'hB0, 8'h5A};
    for (int i = LB - 1; i >= 0; i--) fb.push_back(8'((nw >> (8 * i)) & 255));
    while (pl.size() < nw * BPW) pl.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < nw * BPW; i++) fb.push_back(pl[i]);
    sum = '0;
    foreach (fb[i]) sum = sum + fb[i];
    if (CS) fb.push_back(8'(0 - sum) + cs_off);
    nsent = (cut < 0) ? fb.size() : cut;
    np = (nsent > LB) ? nsent - LB : 0;
    for (int k = 0; k < nw && (k + 1) * BPW <= np; k++) begin
      w = '0;
      for (int j = 0; j < BPW; j++) w = w * 256 + WW'(pl[k * BPW + j]);
      exp_w.push_back(w);
      exp_last.push_back(k == nw - 1);
    end
    if (cut >= 0)          exp_st.push_back(8'h18);
    else if (CS && cs_off) exp_st.push_back(8'h15);
    else                   exp_st.push_back(8'h06);
    repeat ($urandom_range(0, 3)) send_byte(noise_b[$urandom_range(0, 3)]);
    foreach (sync_b[i]) send_byte(sync_b[i]);
    for (int i = 0; i < nsent; i++) send_byte(fb[i]);
    ov = 1'b0;
    if (cut >= 0) repeat (TMO + 10) @(negedge clk);
    t = 0;
    while (exp_st.size() != 0 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) chk("response_wait", 1, 0);
    repeat (2) @(negedge clk);
    chk("busy_after_frame", busy, 0);
    chk("words_drained", exp_w.size(), 0);
    pl.delete();
  endtask

  initial begin
    logic [7:0] d1[8];
    logic [7:0] pre[4];
    logic [7:0] cb;
    d1  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    pre = '{8'hFA, 8'hB0, 8'hFA, 8'hB1};
    repeat (3) @(negedge clk);
    chk("rst_ready", ordy, 0);
    chk("rst_in_valid", ivld, 0);
    chk("rst_in_data", idata, 0);
    chk("rst_strobe", stb, 0);
    chk("rst_wdata", wd, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    foreach (d1[i]) pl.push_back(d1[i]);
    run_frame(2, -1, 8'h00);
    send_byte(8'h00);
    send_byte(8'hFA);
    run_frame(0, -1, 8'h00);
    run_frame(1, LB + 2, 8'h00);
    run_frame(1, 1, 8'h00);
    if (CS) begin
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(1, -1, 8'h00);
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_frame(1, -1, 8'h0B);
    end

    // Reset in the middle of a payload word
    foreach (pre[i]) send_byte(pre[i]);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    ov = 1'b0;
    chk("busy_mid_data", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", ordy, 0);
    chk("mid_rst_in_valid", ivld, 0);
    chk("mid_rst_in_data", idata, 0);
    chk("mid_rst_strobe", stb, 0);
    chk("mid_rst_wdata", wd, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    run_frame(2, -1, 8'h00);

    for (int f = 0; f < 14; f++) begin
      int nw, cut;
      nw  = $urandom_range(0, 3);
      cut = -1;
      if ($urandom_range(0, 3) == 0) cut = $urandom_range(0, LB + nw * BPW - 1);
      cb = (CS && $urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(nw, cut, cb);
    end

    chk("final_words_empty", exp_w.size(), 0);
    chk("final_status_empty", exp_st.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
